alu_seq: RTL and testbench

//  Registered, handshaked successor to the 16-bit combinational ALU: same 4-bit opcode map, WIDTH-parametrised.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_if : valid/ready operand and result channels of the sequential ALU
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             div_zero;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, out, zero, carry, div_zero
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, out, zero, carry, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq : registered handshaked ALU with multi-cycle restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             zero_q;
  logic             carry_q;
  logic             div_zero_q;

  logic             accept;
  logic             retire;
  logic             is_div;
  logic             b_zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign bus.in_ready  = rst_n && (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.div_zero  = div_zero_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign retire = out_valid_q && bus.out_ready;
  assign is_div = (bus.opcode == 4'h3);
  assign b_zero = (bus.b == '0);

  // Remainder shifted left with the next dividend bit; trial[WIDTH] set means "restore"
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.opcode)
      4'h0: alu_res = bus.b;
      4'h1: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      4'h2: alu_res = bus.a * bus.b;
      4'h3: alu_res = '1;
      4'h4: alu_res = {{(WIDTH-1){1'b0}}, bus.a > bus.b};
      4'h5: alu_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      4'h6: alu_res = bus.a >> bus.b;
      4'h7: alu_res = bus.a << bus.b;
      4'h8: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      4'h9: alu_res = $signed(bus.a) >>> bus.b;
      4'hA: alu_res = ~bus.a;
      4'hB: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      4'hC: alu_res = bus.a & bus.b;
      4'hD: alu_res = bus.a | bus.b;
      4'hE: alu_res = bus.a ^ bus.b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_div && !b_zero) begin
              divisor     <= bus.b;
              quo         <= bus.a;
              rem         <= '0;
              count       <= CNT_W'(WIDTH);
              out_valid_q <= 1'b0;
              state       <= DIV;
            end else begin
              // Divide-by-zero falls through here: alu_res is all ones for opcode 3
              out_q       <= alu_res;
              zero_q      <= (alu_res == '0);
              carry_q     <= alu_carry;
              div_zero_q  <= is_div;
              out_valid_q <= 1'b1;
            end
          end else if (retire) begin
            out_valid_q <= 1'b0;
          end
        end
        DIV: begin
          rem   <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          out_q       <= quo;
          zero_q      <= (quo == '0);
          carry_q     <= 1'b0;
          div_zero_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_seq : vector table plus hand sequences, results checked via a queue
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] out;
    logic        zero;
    logic        carry;
    logic        dz;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    res_t        exp;
  } vec_t;

  localparam int NVEC = 33;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];
  res_t cur_exp;
  logic acc;
  vec_t vecs[NVEC];
  vec_t bp[4];
  int   lat;

  function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [3:0] op,
                              logic [15:0] o, logic z, logic c, logic d);
    return {a, b, op, o, z, c, d};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock: observe handshakes mid-cycle, retire before accepting
  task automatic step();
    res_t e;
    res_t got;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      tests++;
      got = {bus.out, bus.zero, bus.carry, bus.div_zero};
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_result got=%h expected none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL result got out=%h z=%b c=%b dz=%b exp out=%h z=%b c=%b dz=%b",
                   got.out, got.zero, got.carry, got.dz, e.out, e.zero, e.carry, e.dz);
        end
      end
    end
    if (acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(vec_t v);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.opcode   = v.op;
    bus.in_valid = 1'b1;
    cur_exp      = v.exp;
  endtask

  task automatic send(vec_t v);
    set_op(v);
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(16'h1234, 16'h00AB, 4'h0, 16'h00AB, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(16'h1234, 16'h1111, 4'h1, 16'h2345, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(16'hFFFF, 16'hFFFF, 4'h1, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(16'h0100, 16'h0101, 4'h2, 16'h0100, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(16'h012C, 16'h012C, 4'h2, 16'h5F90, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(16'h03E8, 16'h0007, 4'h3, 16'h008E, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(16'h0003, 16'h000A, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(16'hFFFF, 16'h0001, 4'h3, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(16'hFFFF, 16'hFFFF, 4'h3, 16'h0001, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(16'h0005, 16'h0000, 4'h3, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    vecs[10] = mk(16'h0005, 16'h0003, 4'h4, 16'h0001, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(16'h0003, 16'h0005, 4'h4, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(16'h0007, 16'h0007, 4'h5, 16'h0001, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(16'h0007, 16'h0008, 4'h5, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(16'h8001, 16'h0014, 4'h6, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[15] = mk(16'h8001, 16'h0001, 4'h6, 16'h4000, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(16'h8001, 16'h0001, 4'h7, 16'h0002, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(16'h0001, 16'h0010, 4'h7, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[18] = mk(16'h0005, 16'h0003, 4'h8, 16'h0002, 1'b0, 1'b0, 1'b0);
    vecs[19] = mk(16'h0003, 16'h0005, 4'h8, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    vecs[20] = mk(16'h0005, 16'h0005, 4'h8, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[21] = mk(16'h8001, 16'h0014, 4'h9, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(16'h8001, 16'h0001, 4'h9, 16'hC000, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(16'h4000, 16'h0002, 4'h9, 16'h1000, 1'b0, 1'b0, 1'b0);
    vecs[24] = mk(16'h00FF, 16'h1234, 4'hA, 16'hFF00, 1'b0, 1'b0, 1'b0);
    vecs[25] = mk(16'h0003, 16'h0005, 4'hB, 16'h0001, 1'b0, 1'b0, 1'b0);
    vecs[26] = mk(16'h0005, 16'h0003, 4'hB, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[27] = mk(16'hF0F0, 16'h3C3C, 4'hC, 16'h3030, 1'b0, 1'b0, 1'b0);
    vecs[28] = mk(16'hF0F0, 16'h0F00, 4'hD, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    vecs[29] = mk(16'hAAAA, 16'hAAAA, 4'hE, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[30] = mk(16'h1234, 16'h5678, 4'hF, 16'h0000, 1'b1, 1'b0, 1'b0);
    vecs[31] = mk(16'h8000, 16'h0003, 4'h3, 16'h2AAA, 1'b0, 1'b0, 1'b0);
    vecs[32] = mk(16'h8000, 16'h8000, 4'h1, 16'h0000, 1'b1, 1'b1, 1'b0);

    bp[0] = mk(16'h0001, 16'h0002, 4'h1, 16'h0003, 1'b0, 1'b0, 1'b0);
    bp[1] = mk(16'h0010, 16'h0020, 4'h1, 16'h0030, 1'b0, 1'b0, 1'b0);
    bp[2] = mk(16'hFFFF, 16'h0002, 4'h1, 16'h0001, 1'b0, 1'b1, 1'b0);
    bp[3] = mk(16'h7000, 16'h1000, 4'h1, 16'h8000, 1'b0, 1'b0, 1'b0);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    cur_exp       = '0;
    acc           = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_flags", 32'({bus.zero, bus.carry, bus.div_zero}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // ADD carry, latency 1
    send(mk(16'hFFFF, 16'h0001, 4'h1, 16'h0000, 1'b1, 1'b1, 1'b0));
    bus.in_valid = 1'b0;
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_out", 32'(bus.out), 32'h0000);
    check("add_carry", 32'(bus.carry), 32'd1);
    check("add_zero", 32'(bus.zero), 32'd1);
    step();

    // Divide by zero, latency 1
    send(mk(16'h0005, 16'h0000, 4'h3, 16'hFFFF, 1'b0, 1'b0, 1'b1));
    bus.in_valid = 1'b0;
    check("dz_valid", 32'(bus.out_valid), 32'd1);
    check("dz_out", 32'(bus.out), 32'hFFFF);
    check("dz_flag", 32'(bus.div_zero), 32'd1);
    check("dz_zero", 32'(bus.zero), 32'd0);
    step();

    // Back-to-back vector stream
    for (int i = 0; i < NVEC; i++) send(vecs[i]);
    drain();

    // Divide latency and busy window
    send(mk(16'd1000, 16'd7, 4'h3, 16'd142, 1'b0, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      check("div_busy_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    check("div_latency", 32'(lat), 32'd17);
    check("div_out", 32'(bus.out), 32'd142);
    drain();

    // Backpressure: result held, no accept, order preserved
    bus.out_ready = 1'b0;
    send(bp[0]);
    set_op(bp[1]);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_out", 32'(bus.out), 32'h0003);
    end
    bus.out_ready = 1'b1;
    send(bp[1]);
    send(bp[2]);
    send(bp[3]);
    drain();

    // Reset in the middle of a divide
    send(mk(16'hFFFF, 16'h0003, 4'h3, 16'h5555, 1'b0, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (20) step();
    check("mid_no_partial", 32'(bus.out_valid), 32'd0);
    send(mk(16'h0007, 16'h0002, 4'hE, 16'h0005, 1'b0, 1'b0, 1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
